rnn_seq_ctrl: RTL and testbench
===============================

RNN_SEQ_CTRL -- requirements
Module: rnn_seq_ctrl

Interface
REQ-001 SHALL have parameter TIMEOUT_CYCLES, default 16'd4096, max cycles allowed in WAIT_IDX or WAIT_DONE.
REQ-002 SHALL have port clk  input  1  single clock, all logic on rising edge.
REQ-003 SHALL have port rst_n  input  1  asynchronous, active-low reset.
REQ-004 SHALL have port start  input  1  one-cycle pulse that begins one inference.
REQ-005 SHALL have port num_words  input  8  input words per inference, sampled on accepted start.
REQ-006 SHALL have port mem_rd_en  output  1  input-buffer read strobe.
REQ-007 SHALL have port mem_addr  output  8  input-buffer word address.
REQ-008 SHALL have port mem_rdata  input  32  buffer read data, valid exactly 1 cycle after mem_rd_en.
REQ-009 SHALL have port rnn_din_index  input  8  next word index requested by the RNN datapath.
REQ-010 SHALL have port rnn_din  output  32  word presented to the RNN datapath.
REQ-011 SHALL have port rnn_valid  output  1  one-cycle qualifier for rnn_din.
REQ-012 SHALL have port rnn_done  input  1  one-cycle pulse, RNN result ready.
REQ-013 SHALL have port rnn_dout  input  32  RNN result, valid while rnn_done=1.
REQ-014 SHALL have ports result (output, 32), result_valid (output, 1), busy (output, 1) and timeout_err (output, 1).

Function
REQ-015 SHALL implement FSM states IDLE, WAIT_IDX, FETCH, PRESENT, WAIT_DONE, ERR.
REQ-016 SHALL accept start only in IDLE or ERR with num_words != 0: latch num_words, clear sent_cnt and timeout_err, go to WAIT_IDX.
REQ-017 SHALL ignore start in any other state, and SHALL ignore start with num_words == 0 (no state change).
REQ-018 SHALL, in WAIT_IDX, go to FETCH on the cycle rnn_din_index == sent_cnt.
REQ-019 SHALL, in FETCH, assert mem_rd_en=1 with mem_addr=sent_cnt for exactly one cycle, then go to PRESENT.
REQ-020 SHALL, in PRESENT, drive rnn_valid=1 with rnn_din=mem_rdata for exactly one cycle and increment sent_cnt (8-bit).
REQ-021 SHALL leave PRESENT for WAIT_DONE when the incremented sent_cnt == latched num_words, otherwise for WAIT_IDX.
REQ-022 SHALL give a minimum index-match-to-rnn_valid latency of 2 cycles (index seen in WAIT_IDX -> FETCH -> PRESENT).
REQ-023 SHALL compare sent_cnt against num_words at full 8 bits; num_words=255 sends indices 0..254, with no wrap.
REQ-024 SHALL, in WAIT_DONE on rnn_done=1: register result<=rnn_dout, pulse result_valid=1 for one cycle, go to IDLE.
REQ-025 SHALL ignore rnn_done in all states except WAIT_DONE.
REQ-026 SHALL keep a 16-bit timeout counter that clears on every state change and increments in WAIT_IDX and WAIT_DONE.
REQ-027 SHALL go to ERR with timeout_err=1 when the timeout counter reaches TIMEOUT_CYCLES.
REQ-028 SHALL hold timeout_err sticky in ERR until the next accepted start.
REQ-029 SHALL drive busy=1 in WAIT_IDX, FETCH, PRESENT and WAIT_DONE, and busy=0 in IDLE and ERR.
REQ-030 SHALL give rnn_done and timeout priority to rnn_done when both occur in the same WAIT_DONE cycle.
REQ-031 SHALL hold result until the next rnn_done captured in WAIT_DONE.
REQ-032 SHALL drive rnn_din=0 whenever rnn_valid=0, and mem_addr=0 whenever mem_rd_en=0.

Reset
REQ-033 SHALL, on rst_n=0 at any time (mid-inference included), immediately enter IDLE with sent_cnt=0, timeout counter=0, mem_rd_en=0, mem_addr=0, rnn_valid=0, rnn_din=0, result=0, result_valid=0, busy=0, timeout_err=0.
REQ-034 SHALL resume operation on the first rising clk edge after rst_n deasserts; no transaction in flight at reset is resumed.

Verification
REQ-035 SHALL cover nominal run: num_words=3, RNN requests indices 0,1,2, mem returns 0x3F800000/0x40000000/0x40400000, rnn_done with rnn_dout=0x3F000000 -> three rnn_valid pulses carrying those words in order, mem_addr 0,1,2, result=0x3F000000, one result_valid pulse, busy low afterwards.
REQ-036 SHALL cover start while busy and start with num_words=0 -> both ignored, and FSM and sent_cnt unchanged.
REQ-037 SHALL cover the RNN holding rnn_din_index=0 after word 0 with TIMEOUT_CYCLES=8 -> ERR after 8 WAIT_IDX cycles, timeout_err=1, busy=0, and a new start clears timeout_err.
REQ-038 SHALL cover rst_n asserted in PRESENT during word 1 of 4 -> all outputs at reset values the same cycle, and a fresh start resends from index 0.
REQ-039 SHALL cover a stray rnn_done in IDLE and in WAIT_IDX -> result unchanged and no result_valid pulse.
REQ-040 SHALL cover num_words=255 -> exactly 255 rnn_valid pulses, the last with mem_addr=254, then WAIT_DONE.

Source files
------------

// File: rtl/rnn_seq_ctrl.sv
// rnn_seq_ctrl: sequences input words from a buffer to an RNN datapath.
// The controller waits for the RNN to request each word index, fetches it, presents it,
// then waits for the RNN result, with a per-state timeout that lands in a sticky ERR.
// Ports:
//   clk, rst_n          clock, async active-low reset
//   start, num_words    begin an inference of num_words words
//   mem_rd_en/addr/rdata  input buffer read port (1-cycle latency)
//   rnn_din_index       next index requested by the RNN
//   rnn_din, rnn_valid  word presented to the RNN
//   rnn_done, rnn_dout  RNN result strobe and data
//   result, result_valid, busy, timeout_err  status/result outputs
module rnn_seq_ctrl #(
    parameter logic [15:0] TIMEOUT_CYCLES = 16'd4096
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [7:0]  num_words,
    output logic        mem_rd_en,
    output logic [7:0]  mem_addr,
    input  logic [31:0] mem_rdata,
    input  logic [7:0]  rnn_din_index,
    output logic [31:0] rnn_din,
    output logic        rnn_valid,
    input  logic        rnn_done,
    input  logic [31:0] rnn_dout,
    output logic [31:0] result,
    output logic        result_valid,
    output logic        busy,
    output logic        timeout_err
);

    typedef enum logic [2:0] {
        IDLE,
        WAIT_IDX,
        FETCH,
        PRESENT,
        WAIT_DONE,
        ERR
    } state_t;

    state_t      state;
    state_t      state_nx;
    logic [7:0]  sent_cnt;
    logic [7:0]  sent_nx;
    logic [7:0]  num_lat;
    logic [15:0] tmo_cnt;
    logic        start_ok;
    logic        tmo_hit;
    logic        done_ok;

    assign start_ok = start && (num_words != 8'd0) &&
                      ((state == IDLE) || (state == ERR));
    assign sent_nx  = sent_cnt + 8'd1;
    // Fires on the cycle whose increment would reach the limit, so the
    // controller spends exactly TIMEOUT_CYCLES cycles in a waiting state.
    assign tmo_hit  = (tmo_cnt + 16'd1) == TIMEOUT_CYCLES;
    assign done_ok  = (state == WAIT_DONE) && rnn_done;

    always_comb begin
        state_nx = state;
        unique case (state)
            IDLE, ERR: begin
                if (start_ok) state_nx = WAIT_IDX;
            end
            WAIT_IDX: begin
                if (rnn_din_index == sent_cnt) state_nx = FETCH;
                else if (tmo_hit)              state_nx = ERR;
            end
            FETCH: state_nx = PRESENT;
            PRESENT: begin
                if (sent_nx == num_lat) state_nx = WAIT_DONE;
                else                    state_nx = WAIT_IDX;
            end
            WAIT_DONE: begin
                // A result arriving on the timeout cycle still counts.
                if (rnn_done)     state_nx = IDLE;
                else if (tmo_hit) state_nx = ERR;
            end
            default: state_nx = IDLE;
        endcase
    end

    assign mem_rd_en = (state == FETCH);
    assign mem_addr  = mem_rd_en ? sent_cnt : 8'd0;
    assign rnn_valid = (state == PRESENT);
    assign rnn_din   = rnn_valid ? mem_rdata : 32'd0;
    assign busy      = (state == WAIT_IDX) || (state == FETCH) ||
                       (state == PRESENT) || (state == WAIT_DONE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= IDLE;
            sent_cnt     <= 8'd0;
            num_lat      <= 8'd0;
            tmo_cnt      <= 16'd0;
            timeout_err  <= 1'b0;
            result       <= 32'd0;
            result_valid <= 1'b0;
        end else begin
            state        <= state_nx;
            result_valid <= done_ok;
            if (start_ok) begin
                num_lat  <= num_words;
                sent_cnt <= 8'd0;
            end else if (state == PRESENT) begin
                sent_cnt <= sent_nx;
            end
            if (state_nx != state) begin
                tmo_cnt <= 16'd0;
            end else if ((state == WAIT_IDX) || (state == WAIT_DONE)) begin
                tmo_cnt <= tmo_cnt + 16'd1;
            end
            if (start_ok) begin
                timeout_err <= 1'b0;
            end else if ((state_nx == ERR) && (state != ERR)) begin
                timeout_err <= 1'b1;
            end
            if (done_ok) begin
                result <= rnn_dout;
            end
        end
    end

endmodule

// File: tb/tb_rnn_seq_ctrl.sv
// tb_rnn_seq_ctrl: directed bench for rnn_seq_ctrl.
// Models the input buffer and a simple auto-requesting RNN.
module tb_rnn_seq_ctrl;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic [7:0]  num_words;
    logic        mem_rd_en;
    logic [7:0]  mem_addr;
    logic [31:0] mem_rdata;
    logic [7:0]  rnn_din_index;
    logic [31:0] rnn_din;
    logic        rnn_valid;
    logic        rnn_done;
    logic [31:0] rnn_dout;
    logic [31:0] result;
    logic        result_valid;
    logic        busy;
    logic        timeout_err;

    int n_checks;
    int n_errs;
    int vcnt;
    int acnt;
    int rvcnt;
    logic        auto_rsp;
    logic [31:0] vlog [256];
    logic [7:0]  alog [256];

    rnn_seq_ctrl #(.TIMEOUT_CYCLES(16'd8)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .start         (start),
        .num_words     (num_words),
        .mem_rd_en     (mem_rd_en),
        .mem_addr      (mem_addr),
        .mem_rdata     (mem_rdata),
        .rnn_din_index (rnn_din_index),
        .rnn_din       (rnn_din),
        .rnn_valid     (rnn_valid),
        .rnn_done      (rnn_done),
        .rnn_dout      (rnn_dout),
        .result        (result),
        .result_valid  (result_valid),
        .busy          (busy),
        .timeout_err   (timeout_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] mem_word(input logic [7:0] a);
        case (a)
            8'd0:    return 32'h3F80_0000;
            8'd1:    return 32'h4000_0000;
            8'd2:    return 32'h4040_0000;
            default: return {24'hA5_0000, a};
        endcase
    endfunction

    always @(posedge clk) begin
        if (mem_rd_en) mem_rdata <= mem_word(mem_addr);
    end

    always @(posedge clk) begin
        if (rnn_valid) begin
            vlog[vcnt[7:0]] = rnn_din;
            vcnt = vcnt + 1;
        end
        if (mem_rd_en) begin
            alog[acnt[7:0]] = mem_addr;
            acnt = acnt + 1;
        end
        if (result_valid) rvcnt = rvcnt + 1;
    end

    always @(negedge clk) begin
        if (auto_rsp && rnn_valid) rnn_din_index = rnn_din_index + 8'd1;
    end

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_checks = n_checks + 1;
        if (got !== exp) begin
            n_errs = n_errs + 1;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic clr_logs;
        vcnt  = 0;
        acnt  = 0;
        rvcnt = 0;
    endtask

    task automatic do_start(input logic [7:0] n);
        start     = 1'b1;
        num_words = n;
        @(negedge clk);
        start     = 1'b0;
        num_words = 8'd0;
    endtask

    task automatic pulse_done(input logic [31:0] d);
        rnn_done = 1'b1;
        rnn_dout = d;
        @(negedge clk);
        rnn_done = 1'b0;
    endtask

    task automatic wait_vcnt(input int n, input int budget);
        int k;
        k = 0;
        while (vcnt < n && k < budget) begin
            @(negedge clk);
            k = k + 1;
        end
        chk("wait_words", vcnt, n);
    endtask

    initial begin
        n_checks      = 0;
        n_errs        = 0;
        auto_rsp      = 1'b0;
        rst_n         = 1'b0;
        start         = 1'b0;
        num_words     = 8'd0;
        rnn_din_index = 8'd0;
        rnn_done      = 1'b0;
        rnn_dout      = 32'd0;
        mem_rdata     = 32'd0;
        clr_logs();

        // reset state
        @(negedge clk);
        @(negedge clk);
        chk("rst_busy", busy, 0);
        chk("rst_rd_en", mem_rd_en, 0);
        chk("rst_addr", mem_addr, 0);
        chk("rst_valid", rnn_valid, 0);
        chk("rst_din", rnn_din, 0);
        chk("rst_result", result, 0);
        chk("rst_rv", result_valid, 0);
        chk("rst_terr", timeout_err, 0);
        rst_n = 1'b1;
        @(negedge clk);

        // nominal 3-word run with latency check
        auto_rsp = 1'b1;
        do_start(8'd3);
        chk("nom_busy", busy, 1);
        chk("nom_wait_rd", mem_rd_en, 0);
        @(negedge clk);
        chk("nom_fetch_rd", mem_rd_en, 1);
        chk("nom_fetch_addr", mem_addr, 0);
        @(negedge clk);
        chk("nom_pres_valid", rnn_valid, 1);
        chk("nom_pres_din", rnn_din, 32'h3F80_0000);
        wait_vcnt(3, 40);
        chk("nom_w0", vlog[0], 32'h3F80_0000);
        chk("nom_w1", vlog[1], 32'h4000_0000);
        chk("nom_w2", vlog[2], 32'h4040_0000);
        chk("nom_a1", alog[1], 1);
        chk("nom_a2", alog[2], 2);
        chk("nom_wd_busy", busy, 1);
        do_start(8'd5);
        chk("busy_start_busy", busy, 1);
        chk("busy_start_vcnt", vcnt, 3);
        chk("busy_start_rd", mem_rd_en, 0);
        pulse_done(32'h3F00_0000);
        chk("nom_rv", result_valid, 1);
        chk("nom_result", result, 32'h3F00_0000);
        chk("nom_idle", busy, 0);
        @(negedge clk);
        chk("nom_rv_low", result_valid, 0);
        chk("nom_rv_cnt", rvcnt, 1);

        // zero-word start and stray done in IDLE
        do_start(8'd0);
        @(negedge clk);
        chk("zero_start", busy, 0);
        chk("zero_vcnt", vcnt, 3);
        pulse_done(32'hDEAD_BEEF);
        @(negedge clk);
        chk("idle_done_res", result, 32'h3F00_0000);
        chk("idle_done_rv", rvcnt, 1);

        // stalled index -> timeout, stray done in WAIT_IDX
        clr_logs();
        auto_rsp      = 1'b0;
        rnn_din_index = 8'd0;
        do_start(8'd4);
        wait_vcnt(1, 10);
        chk("tmo_c1_busy", busy, 1);
        for (int i = 1; i < 8; i++) begin
            rnn_done = (i == 3);
            rnn_dout = 32'h1234_5678;
            @(negedge clk);
        end
        rnn_done = 1'b0;
        chk("tmo_c8_busy", busy, 1);
        chk("tmo_c8_terr", timeout_err, 0);
        @(negedge clk);
        chk("tmo_err_busy", busy, 0);
        chk("tmo_err_flag", timeout_err, 1);
        chk("wi_done_res", result, 32'h3F00_0000);
        chk("wi_done_rv", rvcnt, 0);
        repeat (3) @(negedge clk);
        chk("tmo_sticky", timeout_err, 1);

        // restart from ERR clears the error
        clr_logs();
        rnn_din_index = 8'd0;
        auto_rsp      = 1'b1;
        do_start(8'd2);
        chk("rec_terr", timeout_err, 0);
        chk("rec_busy", busy, 1);
        wait_vcnt(2, 20);
        chk("rec_w1", vlog[1], 32'h4000_0000);
        pulse_done(32'h1122_3344);
        chk("rec_result", result, 32'h1122_3344);

        // reset during PRESENT of word 1 of 4
        clr_logs();
        rnn_din_index = 8'd0;
        do_start(8'd4);
        wait_vcnt(1, 20);
        for (int k = 0; k < 5 && !rnn_valid; k++) @(negedge clk);
        chk("mid_din", rnn_din, 32'h4000_0000);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_valid", rnn_valid, 0);
        chk("mid_rst_din", rnn_din, 0);
        chk("mid_rst_busy", busy, 0);
        chk("mid_rst_rd", mem_rd_en, 0);
        chk("mid_rst_result", result, 0);
        chk("mid_rst_terr", timeout_err, 0);
        @(negedge clk);
        rst_n         = 1'b1;
        rnn_din_index = 8'd0;
        clr_logs();
        @(negedge clk);
        do_start(8'd2);
        wait_vcnt(2, 20);
        chk("post_rst_a0", alog[0], 0);
        chk("post_rst_w0", vlog[0], 32'h3F80_0000);
        pulse_done(32'h0BAD_CAFE);
        chk("post_rst_res", result, 32'h0BAD_CAFE);

        // 255 words, no wrap
        clr_logs();
        rnn_din_index = 8'd0;
        do_start(8'd255);
        wait_vcnt(255, 1200);
        chk("w255_acnt", acnt, 255);
        chk("w255_last_a", alog[254], 254);
        chk("w255_last_w", vlog[254], 32'hA500_00FE);
        chk("w255_busy", busy, 1);
        repeat (3) @(negedge clk);
        chk("w255_no_more", vcnt, 255);
        chk("w255_no_rd", acnt, 255);
        pulse_done(32'hCAFE_F00D);
        chk("w255_result", result, 32'hCAFE_F00D);
        chk("w255_idle", busy, 0);

        $display("Simulation finished: %0d checks, %0d errors",
                 n_checks, n_errs);
        $finish;
    end

endmodule
